// File: rtl/tcdm_bank_arb_pkg.sv
// Shared types and helpers for the TCDM bank arbiter: response pipeline entry and
// the wrapping priority search used by both round-robin and starvation selection.
package tcdm_bank_arb_pkg;

    localparam int unsigned MaxIn   = 256;
    localparam int unsigned MaxIdxW = 8;

    // Index field sized for the largest supported NumIn; instances compare the full field.
    typedef struct packed {
        logic               valid;
        logic [MaxIdxW-1:0] idx;
    } resp_entry_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req at or after ptr, wrapping from n-1 to 0; returns ptr-space index.
    function automatic logic [MaxIdxW-1:0] find_first_from(
        input logic [MaxIn-1:0]   req,
        input logic [MaxIdxW-1:0] ptr,
        input int unsigned        n
    );
        logic [MaxIdxW-1:0] sel;
        logic [MaxIdxW:0]   pos;
        logic               found;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < MaxIn; k++) begin
            if (k < int'(n)) begin
                pos = {1'b0, ptr} + (MaxIdxW+1)'(k);
                if (pos >= (MaxIdxW+1)'(n)) pos = pos - (MaxIdxW+1)'(n);
                if (!found && req[pos[MaxIdxW-1:0]]) begin
                    found = 1'b1;
                    sel   = pos[MaxIdxW-1:0];
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/tcdm_arb_resp_pipe.sv
// RespLat-deep shift register of {valid, idx} entries; the tail decodes into a one-hot
// response-valid vector aligned with the bank's read data.
module tcdm_arb_resp_pipe
    import tcdm_bank_arb_pkg::*;
#(
    parameter int unsigned NumIn   = 8,
    parameter int unsigned RespLat = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  resp_entry_t      i_push,
    output logic [NumIn-1:0] o_vld
);

    resp_entry_t r_pipe [RespLat];

    // NOTE: the entries are reset (unlike a data RAM) so that in-flight responses
    // are dropped and no stale valid can reach the tail after reset is released.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < int'(RespLat); k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= i_push;
            for (int k = 1; k < int'(RespLat); k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    always_comb begin
        o_vld = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            o_vld[i] = r_pipe[RespLat-1].valid && (r_pipe[RespLat-1].idx == MaxIdxW'(i));
        end
    end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank between NumIn initiators, with a fixed-latency
// response return. Optional starvation escalation is compiled in by TCDM_BANK_ARB_STARVE_EN.
module tcdm_bank_arbiter
    import tcdm_bank_arb_pkg::*;
#(
    parameter int unsigned NumIn         = 8,
    parameter int unsigned ReqDataWidth  = 49,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned RespLat       = 1,
    parameter int unsigned WriteRespOn   = 1,
    parameter int unsigned StarveLimit   = 15
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumIn-1:0]                    req_i,
    input  logic [NumIn-1:0]                    wen_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]  data_i,
    output logic [NumIn-1:0]                    gnt_o,
    output logic [NumIn-1:0]                    vld_o,
    output logic [RespDataWidth-1:0]            rdata_o,
    output logic                                req_o,
    input  logic                                gnt_i,
    output logic [ReqDataWidth-1:0]             data_o,
    input  logic [RespDataWidth-1:0]            rdata_i
);

    logic [MaxIdxW-1:0] r_rr_q;
    logic [MaxIn-1:0]   w_req_ext;
    logic [MaxIdxW-1:0] w_rr_win;
    logic [MaxIdxW-1:0] w_win;
    logic               w_win_wen;
    logic               w_hs;
    resp_entry_t        w_push;

    assign w_req_ext = MaxIn'(req_i);
    assign w_rr_win  = find_first_from(w_req_ext, r_rr_q, NumIn);
    assign req_o     = |req_i;
    assign w_hs      = req_o & gnt_i;
    assign rdata_o   = rdata_i;

`ifdef TCDM_BANK_ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(StarveLimit + 1);

    logic [CntW-1:0]    r_wait_q [NumIn];
    logic [MaxIn-1:0]   w_starved;
    logic [MaxIdxW-1:0] w_st_win;

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            w_starved[i] = (r_wait_q[i] == CntW'(StarveLimit));
        end
    end

    // Lowest-index starved requester overrides the round-robin choice.
    assign w_st_win = find_first_from(w_starved, '0, NumIn);
    assign w_win    = (|w_starved) ? w_st_win : w_rr_win;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumIn); i++) r_wait_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NumIn); i++) begin
                if (!req_i[i] || (w_hs && (w_win == MaxIdxW'(i))))
                    r_wait_q[i] <= '0;
                else if (r_wait_q[i] != CntW'(StarveLimit))
                    r_wait_q[i] <= r_wait_q[i] + 1'b1;
            end
        end
    end
`else
    assign w_win = w_rr_win;
`endif

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        gnt_o     = '0;
        data_o    = '0;
        w_win_wen = 1'b0;
        for (int i = 0; i < int'(NumIn); i++) begin
            if (w_win == MaxIdxW'(i)) begin
                gnt_o[i]  = req_i[i] & gnt_i;
                data_o    = data_i[i];
                w_win_wen = wen_i[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_rr_q <= '0;
        else if (w_hs)
            r_rr_q <= (w_win == MaxIdxW'(NumIn - 1)) ? '0 : w_win + 1'b1;
    end

    // An entry is pushed every cycle; a cycle without handshake pushes an invalid one.
    always_comb begin
        w_push       = '0;
        w_push.valid = w_hs & (~w_win_wen | (WriteRespOn != 0));
        w_push.idx   = w_win;
    end

    tcdm_arb_resp_pipe #(
        .NumIn   (NumIn),
        .RespLat (RespLat)
    ) u_resp_pipe (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_push (w_push),
        .o_vld  (vld_o)
    );

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench: three 4-initiator arbiters (RespLat=1 with/without write responses,
// and RespLat=3) share one stimulus stream; expected values are hand-computed.
module tb_tcdm_bank_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N-1:0]           req_i;
    logic [N-1:0]           wen_i;
    logic [N-1:0][DW-1:0]   data_i;
    logic                   gnt_i;
    logic [31:0]            rdata_i;

    logic [N-1:0]  gnt_a, gnt_b, gnt_c;
    logic [N-1:0]  vld_a, vld_b, vld_c;
    logic [31:0]   rdata_a, rdata_b, rdata_c;
    logic          req_a, req_b, req_c;
    logic [DW-1:0] data_a, data_b, data_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    tcdm_bank_arbiter #(.NumIn(N), .ReqDataWidth(DW), .RespDataWidth(32), .RespLat(1),
                        .WriteRespOn(1), .StarveLimit(3)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .wen_i(wen_i), .data_i(data_i),
        .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdata_a), .req_o(req_a), .gnt_i(gnt_i),
        .data_o(data_a), .rdata_i(rdata_i));

    tcdm_bank_arbiter #(.NumIn(N), .ReqDataWidth(DW), .RespDataWidth(32), .RespLat(1),
                        .WriteRespOn(0), .StarveLimit(3)) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .wen_i(wen_i), .data_i(data_i),
        .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdata_b), .req_o(req_b), .gnt_i(gnt_i),
        .data_o(data_b), .rdata_i(rdata_i));

    tcdm_bank_arbiter #(.NumIn(N), .ReqDataWidth(DW), .RespDataWidth(32), .RespLat(3),
                        .WriteRespOn(1), .StarveLimit(3)) u_c (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .wen_i(wen_i), .data_i(data_i),
        .gnt_o(gnt_c), .vld_o(vld_c), .rdata_o(rdata_c), .req_o(req_c), .gnt_i(gnt_i),
        .data_o(data_c), .rdata_i(rdata_i));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_i   = 1'b1;
        req_i   = '0;
        wen_i   = '0;
        gnt_i   = 1'b0;
        rdata_i = 32'h1234_5678;
        for (int i = 0; i < int'(N); i++) data_i[i] = 16'hD000 | 16'(i);

        // Reset state: combinational paths live, responses silent.
        #2;
        check("rst_vld_a", 32'(vld_a), 32'h0);
        check("rst_vld_c", 32'(vld_c), 32'h0);
        check("rst_gnt", 32'(gnt_a), 32'h0);
        check("rst_req_o", 32'(req_a), 32'h0);
        check("rst_rdata", rdata_a, 32'h1234_5678);
        tick();
        tick();
        check("rst_rr", 32'(u_a.r_rr_q), 32'h0);
        check("rst_vld_hold", 32'(vld_b), 32'h0);
        rst_i = 1'b0;

        // Rotation: all request, bank always grants.
        req_i = 4'b1111;
        gnt_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rot_gnt_%0d", k), 32'(gnt_a), 32'(1 << (k % 4)));
            check($sformatf("rot_data_%0d", k), 32'(data_a), 32'(16'hD000 | 16'(k % 4)));
            tick();
            check($sformatf("rot_vld_%0d", k), 32'(vld_a), 32'(1 << (k % 4)));
        end
        req_i = '0;
        #1;
        check("idle_req_o", 32'(req_a), 32'h0);
        tick();
        check("idle_vld", 32'(vld_a), 32'h0);

        // Single load from initiator 2 (pointer at 0).
        req_i = 4'b0100;
        #1;
        check("rd_gnt", 32'(gnt_a), 32'h4);
        check("rd_data", 32'(data_a), 32'hD002);
        tick();
        req_i   = '0;
        rdata_i = 32'hCAFE_0002;
        #1;
        check("rd_vld", 32'(vld_a), 32'h4);
        check("rd_rdata", rdata_a, 32'hCAFE_0002);

        // Store from initiator 1 (pointer at 3 wraps to 1).
        req_i = 4'b0010;
        wen_i = 4'b0010;
        #1;
        check("wr_gnt", 32'(gnt_a), 32'h2);
        tick();
        req_i = '0;
        wen_i = '0;
        check("wr_vld_on", 32'(vld_a), 32'h2);
        check("wr_vld_off", 32'(vld_b), 32'h0);

        // Backpressure: gnt_i 1,0,1 with initiators 0 and 1 (pointer at 2).
        req_i = 4'b0011;
        #1;
        check("bp_gnt0", 32'(gnt_a), 32'h1);
        tick();
        check("bp_vld0", 32'(vld_a), 32'h1);
        gnt_i = 1'b0;
        #1;
        check("bp_gnt_low", 32'(gnt_a), 32'h0);
        check("bp_req_o", 32'(req_a), 32'h1);
        tick();
        check("bp_vld_low", 32'(vld_a), 32'h0);
        check("bp_rr_hold", 32'(u_a.r_rr_q), 32'h1);
        gnt_i = 1'b1;
        #1;
        check("bp_gnt1", 32'(gnt_a), 32'h2);
        tick();
        check("bp_vld1", 32'(vld_a), 32'h2);
        check("bp_l3_vld0", 32'(vld_c), 32'h1);
        req_i = '0;
        tick();
        check("bp_l3_gap", 32'(vld_c), 32'h0);
        tick();
        check("bp_l3_vld1", 32'(vld_c), 32'h2);

        // Starvation run 1: pointer to 0 via initiator 3, then 1001 held off for 3 cycles.
        req_i = 4'b1000;
        #1;
        check("st_pre_gnt", 32'(gnt_a), 32'h8);
        tick();
        req_i = 4'b1001;
        gnt_i = 1'b0;
        #1;
        check("st_hold_gnt", 32'(gnt_a), 32'h0);
        tick();
        tick();
        tick();
        gnt_i = 1'b1;
        #1;
        check("st1_gnt", 32'(gnt_a), 32'h1);
        tick();
        check("st1_rr", 32'(u_a.r_rr_q), 32'h1);
`ifdef TCDM_BANK_ARB_STARVE_EN
        check("st1_wait0", 32'(u_a.r_wait_q[0]), 32'h0);
        check("st1_wait3", 32'(u_a.r_wait_q[3]), 32'h3);
`endif

        // Starvation run 2: pointer at 1, counters cleared, then starve both again.
        req_i = '0;
        tick();
`ifdef TCDM_BANK_ARB_STARVE_EN
        check("st2_wait3_clr", 32'(u_a.r_wait_q[3]), 32'h0);
`endif
        req_i = 4'b1001;
        gnt_i = 1'b0;
        tick();
        tick();
        tick();
        gnt_i = 1'b1;
        #1;
`ifdef TCDM_BANK_ARB_STARVE_EN
        check("st2_gnt", 32'(gnt_a), 32'h1);
`else
        check("st2_gnt", 32'(gnt_a), 32'h8);
`endif
        tick();
        req_i = '0;
        tick();

        // Reset mid-flight on the RespLat=3 instance.
        req_i = 4'b0001;
        #1;
        check("rf_gnt", 32'(gnt_c), 32'h1);
        tick();
        req_i = '0;
        rst_i = 1'b1;
        #1;
        check("rf_vld_c1", 32'(vld_c), 32'h0);
        tick();
        check("rf_vld_c2", 32'(vld_c), 32'h0);
        rst_i = 1'b0;
        check("rf_rr", 32'(u_c.r_rr_q), 32'h0);
        tick();
        check("rf_vld_c3", 32'(vld_c), 32'h0);
        tick();
        check("rf_vld_c4", 32'(vld_c), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
